// File: rtl/bubble_sort_ctrl_pkg.sv
// Shared types and width helpers for the bubble-sort controller slice.
package sort_pkg;

  typedef enum logic [1:0] {S_LOAD, S_SORT, S_DRAIN} sort_state_t;

  // Width of an index into an n-entry array (at least one bit).
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width able to hold the worst-case swap total n*(n-1)/2.
  function automatic int cnt_width(input int n);
    return $clog2(n * (n - 1) / 2 + 1);
  endfunction

endpackage

// File: rtl/bubble_sort_ctrl_if.sv
// Load/drain stream and status bundle between the sorter and its producer/consumer.
interface bubble_sort_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ELEMS  = 8
);
  import sort_pkg::*;

  localparam int CW = cnt_width(NUM_ELEMS);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;
  logic                  busy;
  logic                  done;
  logic [CW-1:0]         swap_cnt;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, done, swap_cnt
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, done, swap_cnt
  );

endinterface

// File: rtl/bubble_sort_ctrl_datapath.sv
// Combinational compare-swap unit: orders a pair ascending, strict greater-than so
// equal words keep their order.
module Datapath #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic [DATA_WIDTH-1:0] data2,
  output logic                  swap,
  output logic [DATA_WIDTH-1:0] swap_data1,
  output logic [DATA_WIDTH-1:0] swap_data2
);

  // Clock and reset are carried for a future pipelined variant; nothing uses them yet.
  logic w_unused;
  assign w_unused = ^{clk, reset};

  assign swap       = (data1 > data2);
  assign swap_data1 = swap ? data2 : data1;
  assign swap_data2 = swap ? data1 : data2;

endmodule

// File: rtl/bubble_sort_ctrl.sv
// In-place bubble sort of one NUM_ELEMS batch: stream in, sort ascending with
// early exit, stream out. One batch in flight.
module bubble_sort_ctrl
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ELEMS  = 8
) (
  input  logic               clk,
  input  logic               reset,
  bubble_sort_ctrl_if.slave  bus
);

  localparam int IW = idx_width(NUM_ELEMS);
  localparam int CW = cnt_width(NUM_ELEMS);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_ELEMS - 1);
  localparam logic [IW-1:0] FIRST_LIM = IW'(NUM_ELEMS - 2);

  sort_state_t r_state, w_state_nxt;

  logic [DATA_WIDTH-1:0] r_mem [NUM_ELEMS];
  logic [IW-1:0]         r_wr_idx;
  logic [IW-1:0]         r_rd_idx;
  logic [IW-1:0]         r_j;
  logic [IW-1:0]         r_pass;
  logic                  r_pass_swapped;
  logic [CW-1:0]         r_swap_cnt;
  logic                  r_done;

  logic [IW-1:0]         w_j_p1;
  logic [IW-1:0]         w_limit;
  logic                  w_end_pass;
  logic                  w_sort_exit;
  logic                  w_swap;
  logic [DATA_WIDTH-1:0] w_data1;
  logic [DATA_WIDTH-1:0] w_data2;
  logic [DATA_WIDTH-1:0] w_swap_data1;
  logic [DATA_WIDTH-1:0] w_swap_data2;
  logic                  w_in_ready;
  logic                  w_out_valid;
  logic                  w_busy;
  logic                  w_load_hs;
  logic                  w_drain_hs;
  logic                  w_rd_last;

  assign w_j_p1     = r_j + IW'(1);
  assign w_limit    = FIRST_LIM - r_pass;
  assign w_end_pass = (r_j == w_limit);
  // The current compare counts toward "this pass swapped", so a swap on the last
  // pair of a pass still forces another pass.
  assign w_sort_exit = w_end_pass && (!(r_pass_swapped || w_swap) || (w_limit == '0));

  assign w_data1 = r_mem[r_j];
  assign w_data2 = r_mem[w_j_p1];

  Datapath #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .data1      (w_data1),
    .data2      (w_data2),
    .swap       (w_swap),
    .swap_data1 (w_swap_data1),
    .swap_data2 (w_swap_data2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && (r_wr_idx == LAST_IDX)) begin
          w_state_nxt = S_SORT;
        end
      end
      S_SORT: begin
        w_busy = 1'b1;
        if (w_sort_exit) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready && (r_rd_idx == LAST_IDX)) begin
          w_state_nxt = S_LOAD;
        end
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  assign w_load_hs  = bus.in_valid && w_in_ready;
  assign w_drain_hs = w_out_valid && bus.out_ready;
  assign w_rd_last  = w_out_valid && (r_rd_idx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ELEMS; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_idx       <= '0;
      r_rd_idx       <= '0;
      r_j            <= '0;
      r_pass         <= '0;
      r_pass_swapped <= 1'b0;
      r_swap_cnt     <= '0;
      r_done         <= 1'b0;
    end else begin
      r_done <= w_drain_hs && w_rd_last;
      case (r_state)
        S_LOAD: begin
          if (w_load_hs) begin
            r_mem[r_wr_idx] <= bus.in_data;
            if (r_wr_idx == LAST_IDX) begin
              r_wr_idx       <= '0;
              r_j            <= '0;
              r_pass         <= '0;
              r_pass_swapped <= 1'b0;
              r_swap_cnt     <= '0;
            end else begin
              r_wr_idx <= r_wr_idx + IW'(1);
            end
          end
        end
        S_SORT: begin
          r_mem[r_j]    <= w_swap_data1;
          r_mem[w_j_p1] <= w_swap_data2;
          if (w_swap) begin
            r_pass_swapped <= 1'b1;
            r_swap_cnt     <= r_swap_cnt + CW'(1);
          end
          if (w_sort_exit) begin
            r_rd_idx <= '0;
          end else if (w_end_pass) begin
            r_pass         <= r_pass + IW'(1);
            r_j            <= '0;
            r_pass_swapped <= 1'b0;
          end else begin
            r_j <= w_j_p1;
          end
        end
        S_DRAIN: begin
          if (w_drain_hs) begin
            r_rd_idx <= w_rd_last ? '0 : (r_rd_idx + IW'(1));
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_mem[r_rd_idx];
  assign bus.out_last  = w_rd_last;
  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign bus.swap_cnt  = r_swap_cnt;

endmodule
